// File: rtl/joypad_reader_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : joypad_reader_if                                         |
// | Description : Pad-side wires plus the parallel result bus of the       |
// |               two-port serial joypad reader.                           |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface joypad_reader_if;
    logic            poll;
    logic [1:0]      pad_data;
    logic            pad_latch;
    logic            pad_clock;
    logic [1:0][7:0] buttons;
    logic            valid;
    logic            busy;

    modport master (
        input  poll,
        input  pad_data,
        output pad_latch,
        output pad_clock,
        output buttons,
        output valid,
        output busy
    );

    modport slave (
        output poll,
        output pad_data,
        input  pad_latch,
        input  pad_clock,
        input  buttons,
        input  valid,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/joypad_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : joypad_reader                                            |
// | Description : Polls two NES-style serial pads over a shared latch and  |
// |               clock, returns one active-high button byte per pad.      |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module joypad_reader #(
    parameter int LATCH_CYCLES = 258,
    parameter int HALF_CYCLES  = 129,
    parameter int SYNC_STAGES  = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    joypad_reader_if.master bus
);

    localparam int C_MAX   = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int C_CNT_W = $clog2(C_MAX) + 1;
    localparam logic [C_CNT_W-1:0] C_LATCH_LOAD = C_CNT_W'(LATCH_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_HALF_LOAD  = C_CNT_W'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_GAP   = 3'd2,
        S_LOW   = 3'd3,
        S_HIGH  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [2:0]          r_bit;
    logic [1:0][7:0]     r_shadow;
    logic [1:0][7:0]     r_buttons;
    logic                r_latch;
    logic                r_pclk;
    logic                r_valid;
    logic                r_busy;
    logic [1:0]          w_synced;

    // Synchronisers reset to 1 so an absent pad reads as released.
    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync <= '1;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pad_data[p]};
                end
            end
            assign w_synced[p] = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shadow  <= '0;
            r_buttons <= '0;
            r_latch   <= 1'b0;
            r_pclk    <= 1'b1;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.poll) begin
                        r_state <= S_LATCH;
                        r_cnt   <= C_LATCH_LOAD;
                        r_latch <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (r_cnt == '0) begin
                        r_state <= S_GAP;
                        r_cnt   <= C_HALF_LOAD;
                        r_latch <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        for (int i = 0; i < 2; i++) r_shadow[i][0] <= ~w_synced[i];
                        r_bit   <= 3'd1;
                        r_state <= S_LOW;
                        r_cnt   <= C_HALF_LOAD;
                        r_pclk  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_W'(1);
                    end
                end
                S_LOW: begin
                    if (r_cnt == '0) begin
                        r_state <= S_HIGH;
                        r_cnt   <= C_HALF_LOAD;
                        r_pclk  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (r_cnt == '0) begin
                        for (int i = 0; i < 2; i++) r_shadow[i][r_bit] <= ~w_synced[i];
                        if (r_bit == 3'd7) begin
                            // Last bit merges straight into the result so both ports update together with valid.
                            for (int i = 0; i < 2; i++) r_buttons[i] <= {~w_synced[i], r_shadow[i][6:0]};
                            r_state <= S_DONE;
                            r_cnt   <= '0;
                            r_valid <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_state <= S_LOW;
                            r_cnt   <= C_HALF_LOAD;
                            r_pclk  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - C_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_latch <= 1'b0;
                    r_pclk  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pad_latch = r_latch;
    assign bus.pad_clock = r_pclk;
    assign bus.buttons   = r_buttons;
    assign bus.valid     = r_valid;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_joypad_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_joypad_reader                                         |
// | Description : Scoreboard bench for joypad_reader with shift-register   |
// |               pad models and a cycle-accurate expected-waveform model. |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_joypad_reader;

    // HALF_CYCLES must be at least SYNC_STAGES+1 for bit k to cross the synchroniser before it is sampled.
    localparam int L    = 4;
    localparam int H    = 3;
    localparam int S    = 2;
    localparam int VOFF = 1 + L + 15 * H;
    localparam int PER  = L + 15 * H + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    joypad_reader_if bus();

    joypad_reader #(
        .LATCH_CYCLES(L),
        .HALF_CYCLES (H),
        .SYNC_STAGES (S)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Pad models: mode 0 = shift register, 1 = line tied high, 2 = line tied low.
    logic [7:0] btn  [2];
    int         mode [2];
    logic [7:0] sr   [2];

    initial begin
        sr[0] = 8'hFF;
        sr[1] = 8'hFF;
    end

    always @(posedge bus.pad_clock or posedge bus.pad_latch) begin
        for (int i = 0; i < 2; i++) begin
            if (bus.pad_latch) sr[i] <= ~btn[i];
            else               sr[i] <= {1'b1, sr[i][7:1]};
        end
    end

    always_comb begin
        bus.pad_data = 2'b11;
        for (int i = 0; i < 2; i++) begin
            case (mode[i])
                1:       bus.pad_data[i] = 1'b1;
                2:       bus.pad_data[i] = 1'b0;
                default: bus.pad_data[i] = sr[i][0];
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] pad_word(input int i);
        case (mode[i])
            1:       return 8'h00;
            2:       return 8'hFF;
            default: return btn[i];
        endcase
    endfunction

    typedef struct {
        logic [15:0] word;
        int          at;
    } exp_t;
    exp_t q[$];

    // Model: acc is the cycle whose following edge started the current poll.
    int acc     = -100000;
    int free_at = 0;

    initial begin
        int   o;
        logic e_busy, e_latch, e_clk;
        exp_t e;
        forever begin
            @(negedge clk);
            e_busy  = (cyc >= acc + 1) && (cyc <= acc + PER - 1);
            e_latch = (cyc >= acc + 1) && (cyc <= acc + L);
            o       = cyc - (acc + 1 + L + H);
            e_clk   = !((o >= 0) && (o < 14 * H) && (((o / H) % 2) == 0));
            check_val("busy", 32'(bus.busy), 32'(e_busy));
            check_val("latch", 32'(bus.pad_latch), 32'(e_latch));
            check_val("pad_clock", 32'(bus.pad_clock), 32'(e_clk));
            if (bus.valid) begin
                if (q.size() == 0) begin
                    check_val("valid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check_val("buttons", 32'(bus.buttons), 32'(e.word));
                    check_val("valid_cycle", 32'(cyc), 32'(e.at));
                end
            end
            if (q.size() > 0 && cyc > q[0].at) begin
                check_val("valid_missing", 32'd0, 32'd1);
                void'(q.pop_front());
            end
            if (!rst_n) begin
                q.delete();
                acc     = -100000;
                free_at = cyc + 1;
            end else if (bus.poll && cyc >= free_at) begin
                e.word  = {pad_word(1), pad_word(0)};
                e.at    = cyc + VOFF;
                q.push_back(e);
                acc     = cyc;
                free_at = cyc + PER;
            end
        end
    end

    task automatic do_poll();
        @(posedge clk) #1 bus.poll = 1'b1;
        @(posedge clk) #1 bus.poll = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while ((q.size() != 0 || bus.busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check_val("timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        bus.poll = 1'b0;
        mode[0] = 0; mode[1] = 0;
        btn[0]  = 8'h00; btn[1] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_buttons", 32'(bus.buttons), 32'h0);
        check_val("rst_valid", 32'(bus.valid), 32'h0);

        // A+Start on pad 0, Right on pad 1
        btn[0] = 8'h09; btn[1] = 8'h80;
        do_poll();
        wait_idle();
        check_val("t1_word", 32'(bus.buttons), 32'h8009);

        mode[0] = 1; mode[1] = 1;
        do_poll();
        wait_idle();
        check_val("tied_high", 32'(bus.buttons), 32'h0000);
        mode[0] = 2; mode[1] = 2;
        do_poll();
        wait_idle();
        check_val("tied_low", 32'(bus.buttons), 32'hFFFF);

        // Held poll: back-to-back polls with a single idle cycle between
        mode[0] = 0; mode[1] = 0;
        btn[0] = 8'h11; btn[1] = 8'h22;
        @(posedge clk) #1 bus.poll = 1'b1;
        repeat (120) @(posedge clk);
        #1 bus.poll = 1'b0;
        wait_idle();

        // Second pulse mid-poll must be ignored
        btn[0] = 8'h42; btn[1] = 8'h24;
        do_poll();
        repeat (8) @(posedge clk);
        #1 bus.poll = 1'b1;
        @(posedge clk) #1 bus.poll = 1'b0;
        wait_idle();
        check_val("ignored_word", 32'(bus.buttons), 32'h2442);

        // Reset in the middle of a poll
        btn[0] = 8'hA5; btn[1] = 8'h5A;
        do_poll();
        repeat (18) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk) #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("abort_buttons", 32'(bus.buttons), 32'h0);
        check_val("abort_latch", 32'(bus.pad_latch), 32'h0);
        check_val("abort_clock", 32'(bus.pad_clock), 32'h1);
        check_val("abort_busy", 32'(bus.busy), 32'h0);
        repeat (80) @(negedge clk);

        // Walking single button on pad 0, bit order check
        btn[1] = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            btn[0] = 8'(1 << i);
            do_poll();
            wait_idle();
            check_val("walk_pad0", 32'(bus.buttons[0]), 32'(1 << i));
            check_val("walk_pad1", 32'(bus.buttons[1]), 32'h3C);
        end

        check_val("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
